fetch_ctrl: RTL and testbench

- Owns the program counter and drives instruction-memory fetch requests.
- Produces pc_next, the sequential-path input of the PC branch mux.
- Consumes the mux output as the redirect target when a branch is taken.
- Holds one outstanding request, squashes stale responses after redirects, and buffers the fetched instruction in a single-entry valid/ready skid register toward decode.

---
 rtl/fetch_ctrl.sv | 131 +++++++++++++
 tb/tb_fetch_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Fetch controller: owns the PC, issues one outstanding imem request at a time,
// squashes stale responses after redirects and buffers one instruction toward
// decode. Optional misaligned-PC trap is enabled with FETCH_MISALIGN_TRAP_EN.
module fetch_ctrl #(
  parameter int                   AddrWidth  = 32,
  parameter int                   InstrWidth = 32,
  parameter logic [AddrWidth-1:0] ResetAddr  = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [AddrWidth-1:0]  pc_next,
  input  logic [AddrWidth-1:0]  pc_mux_out,
  input  logic                  branch_taken,
  output logic [AddrWidth-1:0]  pc,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [AddrWidth-1:0]  imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [InstrWidth-1:0] imem_rsp_data,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [InstrWidth-1:0] instr,
  output logic [AddrWidth-1:0]  instr_pc,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic                  misalign_trap,
`endif
  output logic [1:0]            state_dbg
);

  // Handshakes: a transfer happens on a cycle where valid && ready are both
  // high at the clock edge; valid never depends on ready of the same channel.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
`ifdef FETCH_MISALIGN_TRAP_EN
    S_TRAP = 2'd3,
`endif
    S_WAIT = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [AddrWidth-1:0]   req_pc_q;
  logic                   kill_q;
  logic                   misaligned;
  logic                   redirect;
  logic                   req_fire;
  logic [AddrWidth-1:0]   redirect_target;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign misaligned      = (pc[1:0] != 2'b00);
  assign redirect_target = pc_mux_out;
`else
  assign misaligned      = 1'b0;
  assign redirect_target = {pc_mux_out[AddrWidth-1:2], 2'b00};
`endif

  assign pc_next       = pc + AddrWidth'(4);
  assign imem_req_addr = pc;
  assign state_dbg     = state_q;
  assign redirect      = branch_taken && (state_q != S_IDLE);
  assign req_fire      = imem_req_valid && imem_req_ready;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (branch_taken)  state_d = S_REQ;
`ifdef FETCH_MISALIGN_TRAP_EN
        else if (misaligned) state_d = S_TRAP;
`endif
        else if (req_fire) state_d = S_WAIT;
      end
      S_WAIT: if (imem_rsp_valid) state_d = S_REQ;
`ifdef FETCH_MISALIGN_TRAP_EN
      S_TRAP: if (branch_taken) state_d = S_REQ;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // A request issues only if the buffer is empty or draining this cycle.
  always_comb begin
    imem_req_valid = (state_q == S_REQ) && !branch_taken && !misaligned &&
                     (!instr_valid || instr_ready);
`ifdef FETCH_MISALIGN_TRAP_EN
    misalign_trap  = (state_q == S_REQ) && !branch_taken && misaligned;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= ResetAddr;
      req_pc_q    <= '0;
      kill_q      <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
    end else begin
      if (redirect) begin
        pc <= redirect_target;
      end else if (req_fire) begin
        pc       <= pc_next;
        req_pc_q <= pc;
      end

      // kill marks the single in-flight response as stale after a redirect.
      if (state_q == S_WAIT) begin
        if (imem_rsp_valid)    kill_q <= 1'b0;
        else if (branch_taken) kill_q <= 1'b1;
      end

      if (redirect) begin
        instr_valid <= 1'b0;
      end else if ((state_q == S_WAIT) && imem_rsp_valid && !kill_q) begin
        instr_valid <= 1'b1;
        instr       <= imem_rsp_data;
        instr_pc    <= req_pc_q;
      end else if (instr_valid && instr_ready) begin
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Cycle-accurate directed bench for fetch_ctrl: a table of per-cycle inputs and
// hand-computed expected outputs, plus a reset/stray-response sequence.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_next;
  logic [31:0] pc_mux_out;
  logic        branch_taken;
  logic [31:0] pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [1:0]  state_dbg;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_trap;
`endif

  fetch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .pc_next        (pc_next),
    .pc_mux_out     (pc_mux_out),
    .branch_taken   (branch_taken),
    .pc             (pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
`ifdef FETCH_MISALIGN_TRAP_EN
    .misalign_trap  (misalign_trap),
`endif
    .state_dbg      (state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        bt;
    logic [31:0] mux;
    logic        rr;
    logic        rv;
    logic [31:0] rd;
    logic        ir;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_instr;
    logic [31:0] e_ipc;
    logic        e_trap;
  } vec_t;

  vec_t vecs[$];
  int   tests  = 0;
  int   failed = 0;

  function automatic logic [31:0] dat(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic add(input logic bt, input logic [31:0] mux, input logic rr,
                     input logic rv, input logic [31:0] rd, input logic ir,
                     input logic e_req, input logic [31:0] e_addr, input logic e_iv,
                     input logic [31:0] e_instr, input logic [31:0] e_ipc,
                     input logic e_trap);
    vec_t v;
    v.bt = bt; v.mux = mux; v.rr = rr; v.rv = rv; v.rd = rd; v.ir = ir;
    v.e_req = e_req; v.e_addr = e_addr; v.e_iv = e_iv;
    v.e_instr = e_instr; v.e_ipc = e_ipc; v.e_trap = e_trap;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int cyc,
                       input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    branch_taken   = v.bt;
    pc_mux_out     = v.mux;
    imem_req_ready = v.rr;
    imem_rsp_valid = v.rv;
    imem_rsp_data  = v.rd;
    instr_ready    = v.ir;
  endtask

  initial begin
    reset = 1'b1; branch_taken = 1'b0; pc_mux_out = '0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; instr_ready = 1'b0;

    // Fetch 0x0, 0x4, 0x8 back to back, then redirect to 0x100 while waiting on 0x8.
    add(0, 0, 1, 0, 0, 1,                    0, 32'h0,   0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 1,                    1, 32'h0,   0, 0, 0, 0);
    add(0, 0, 1, 1, dat(32'h0), 1,           0, 32'h4,   0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 1,                    1, 32'h4,   1, dat(32'h0), 32'h0, 0);
    add(0, 0, 1, 1, dat(32'h4), 1,           0, 32'h8,   0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 1,                    1, 32'h8,   1, dat(32'h4), 32'h4, 0);
    add(1, 32'h100, 1, 0, 0, 1,              0, 32'hC,   0, 0, 0, 0);
    add(0, 0, 1, 1, dat(32'h8), 1,           0, 32'h100, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 1,                    1, 32'h100, 0, 0, 0, 0);
    add(0, 0, 1, 1, dat(32'h100), 1,         0, 32'h104, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 1,                    1, 32'h104, 1, dat(32'h100), 32'h100, 0);
    // Redirect coinciding with the response.
    add(1, 32'h200, 1, 1, dat(32'h104), 1,   0, 32'h108, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 1,                    1, 32'h200, 0, 0, 0, 0);
    add(0, 0, 1, 1, dat(32'h200), 1,         0, 32'h204, 0, 0, 0, 0);
    // Decode stalls for 5 cycles with the buffer full.
    for (int i = 0; i < 5; i++)
      add(0, 0, 1, 0, 0, 0,                  0, 32'h204, 1, dat(32'h200), 32'h200, 0);
    add(0, 0, 1, 0, 0, 1,                    1, 32'h204, 1, dat(32'h200), 32'h200, 0);
    add(0, 0, 1, 1, dat(32'h204), 1,         0, 32'h208, 0, 0, 0, 0);
    // Memory not ready for 3 cycles.
    add(0, 0, 0, 0, 0, 1,                    1, 32'h208, 1, dat(32'h204), 32'h204, 0);
    add(0, 0, 0, 0, 0, 1,                    1, 32'h208, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1,                    1, 32'h208, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 1,                    1, 32'h208, 0, 0, 0, 0);
    add(0, 0, 1, 1, dat(32'h208), 1,         0, 32'h20C, 0, 0, 0, 0);
    // Redirect in REQ to the top word, then wrap to 0.
    add(1, 32'hFFFF_FFFC, 1, 0, 0, 1,        0, 32'h20C, 1, dat(32'h208), 32'h208, 0);
    add(0, 0, 1, 0, 0, 1,                    1, 32'hFFFF_FFFC, 0, 0, 0, 0);
    add(0, 0, 1, 1, dat(32'hFFFF_FFFC), 1,   0, 32'h0,   0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 1,                    1, 32'h0,   1, dat(32'hFFFF_FFFC), 32'hFFFF_FFFC, 0);
    add(0, 0, 1, 1, dat(32'h0), 1,           0, 32'h4,   0, 0, 0, 0);
    // Redirect to a misaligned target.
    add(1, 32'h102, 1, 0, 0, 1,              0, 32'h4,   1, dat(32'h0), 32'h0, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
    add(0, 0, 1, 0, 0, 1,                    0, 32'h102, 0, 0, 0, 1);
    add(0, 0, 1, 0, 0, 1,                    0, 32'h102, 0, 0, 0, 0);
    add(1, 32'h200, 1, 0, 0, 1,              0, 32'h102, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 1,                    1, 32'h200, 0, 0, 0, 0);
    add(0, 0, 1, 1, dat(32'h200), 1,         0, 32'h204, 0, 0, 0, 0);
`else
    add(0, 0, 1, 0, 0, 1,                    1, 32'h100, 0, 0, 0, 0);
    add(0, 0, 1, 1, dat(32'h100), 1,         0, 32'h104, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 1,                    1, 32'h104, 1, dat(32'h100), 32'h100, 0);
`endif

    repeat (2) @(posedge clk);
    #1;
    check("rst_req_valid", -1, 32'(imem_req_valid), 32'h0);
    check("rst_instr_valid", -1, 32'(instr_valid), 32'h0);
    check("rst_pc", -1, pc, 32'h0);
    check("rst_pc_next", -1, pc_next, 32'h4);
    check("rst_instr", -1, instr, 32'h0);
    check("rst_instr_pc", -1, instr_pc, 32'h0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(negedge clk);
      check("req_valid", i, 32'(imem_req_valid), 32'(vecs[i].e_req));
      check("req_addr", i, imem_req_addr, vecs[i].e_addr);
      check("pc", i, pc, vecs[i].e_addr);
      check("pc_next", i, pc_next, vecs[i].e_addr + 32'd4);
      check("instr_valid", i, 32'(instr_valid), 32'(vecs[i].e_iv));
      if (vecs[i].e_iv) begin
        check("instr", i, instr, vecs[i].e_instr);
        check("instr_pc", i, instr_pc, vecs[i].e_ipc);
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      check("misalign_trap", i, 32'(misalign_trap), 32'(vecs[i].e_trap));
`endif
      @(posedge clk);
      #1;
    end

    // Reset mid-operation with a stray response arriving across and after it.
    reset = 1'b1; branch_taken = 1'b0; imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'hBAD0_BAD0; imem_req_ready = 1'b0; instr_ready = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("stray_idle_req_valid", 100, 32'(imem_req_valid), 32'h0);
    check("stray_idle_instr_valid", 100, 32'(instr_valid), 32'h0);
    check("stray_idle_pc", 100, pc, 32'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("stray_req_valid", 101, 32'(imem_req_valid), 32'h1);
    check("stray_req_addr", 101, imem_req_addr, 32'h0);
    check("stray_req_instr_valid", 101, 32'(instr_valid), 32'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("stray_hold_instr_valid", 102, 32'(instr_valid), 32'h0);
    check("stray_hold_instr", 102, instr, 32'h0);
    check("stray_hold_addr", 102, imem_req_addr, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
